// File: rtl/vend_pkg.sv
// Shared definitions for the candy-vending customer and the vending machine:
// coin values, default price, error codes, FSM encoding and small helpers.
package vend_pkg;

    localparam int NICKEL_CENTS  = 5;
    localparam int DIME_CENTS    = 10;
    localparam int QUARTER_CENTS = 25;
    localparam int DEFAULT_PRICE = 25;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_FUNDS   = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_CHANGE  = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_INSERT,
        ST_GAP,
        ST_WAIT_VEND,
        ST_THANK,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME,
        COIN_QUARTER
    } coin_e;

    // Largest coin first, so the purchase uses as few coins as possible.
    function automatic coin_e pick_coin(logic [2:0] n, logic [2:0] d, logic [1:0] q);
        if (q != 2'd0)      return COIN_QUARTER;
        else if (d != 3'd0) return COIN_DIME;
        else if (n != 3'd0) return COIN_NICKEL;
        else                return COIN_NONE;
    endfunction

    // Wallet total; the largest wallet (7 nickels, 7 dimes, 3 quarters) is 180 cents.
    function automatic logic [7:0] wallet_cents(logic [2:0] n, logic [2:0] d, logic [1:0] q);
        return 8'(n) * 8'(NICKEL_CENTS) + 8'(d) * 8'(DIME_CENTS) + 8'(q) * 8'(QUARTER_CENTS);
    endfunction

    function automatic logic [6:0] coin_cents(coin_e c);
        case (c)
            COIN_QUARTER: return 7'(QUARTER_CENTS);
            COIN_DIME:    return 7'(DIME_CENTS);
            COIN_NICKEL:  return 7'(NICKEL_CENTS);
            default:      return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_customer_if.sv
// Customer <-> machine signal bundle. The master side is the customer FSM,
// the slave side is the machine (or the environment driving the customer).
interface vend_customer_if;
    import vend_pkg::*;

    logic       start;
    logic [2:0] nickel_cnt;
    logic [2:0] dime_cnt;
    logic [1:0] quarter_cnt;
    logic       candy_in;
    logic       nickel_ret_in;
    logic [1:0] dime_ret_in;
    logic       nickel_out;
    logic       dime_out;
    logic       quarter_out;
    logic       thanks_out;
    logic       busy;
    logic       done;
    logic [5:0] change_cents;
    logic       vend_ok;
    err_e       err;

    modport master (
        input  start, nickel_cnt, dime_cnt, quarter_cnt,
        input  candy_in, nickel_ret_in, dime_ret_in,
        output nickel_out, dime_out, quarter_out, thanks_out,
        output busy, done, change_cents, vend_ok, err
    );

    modport slave (
        output start, nickel_cnt, dime_cnt, quarter_cnt,
        output candy_in, nickel_ret_in, dime_ret_in,
        input  nickel_out, dime_out, quarter_out, thanks_out,
        input  busy, done, change_cents, vend_ok, err
    );

endinterface

// File: rtl/vend_change_decode.sv
// Decodes the machine's change report into cents. Dime change is thermometer
// coded (00, 01, 11); 10 is flagged illegal but still decodes as one dime.
module vend_change_decode
    import vend_pkg::*;
(
    input  logic       nickel_ret_in,
    input  logic [1:0] dime_ret_in,
    output logic [5:0] change_cents,
    output logic       illegal
);

    logic [1:0] dime_count;

    // Pure decode of the change strobe fields.
    always_comb begin
        // NOTE: every output is assigned on every path through always_comb, so no latch is inferred.
        dime_count   = 2'(dime_ret_in[0]) + 2'(dime_ret_in[1]);
        change_cents = (nickel_ret_in ? 6'(NICKEL_CENTS) : 6'd0) + 6'(dime_count) * 6'(DIME_CENTS);
        illegal      = (dime_ret_in == 2'b10);
    end

endmodule

// File: rtl/vend_customer.sv
// Customer side of a candy purchase: checks the wallet, feeds coins one at a
// time (largest first, one idle cycle between coins) until the price is met,
// waits for the candy strobe, acknowledges it and reports change and status.
module vend_customer
    import vend_pkg::*;
#(
    parameter int PRICE        = DEFAULT_PRICE,
    parameter int VEND_TIMEOUT = 8
) (
    input logic             clk,
    input logic             rst_n,
    vend_customer_if.master bus
);

    localparam int               CNT_W       = $clog2(VEND_TIMEOUT + 1);
    localparam logic [7:0]       PRICE_CENTS = 8'(PRICE);
    localparam logic [CNT_W-1:0] LAST_WAIT   = CNT_W'(VEND_TIMEOUT - 1);

    state_e           state;
    logic [2:0]       n_left;
    logic [2:0]       d_left;
    logic [1:0]       q_left;
    logic [6:0]       paid;
    logic [CNT_W-1:0] wait_cnt;

    logic [5:0] ret_cents;
    logic       ret_illegal;
    coin_e      next_coin;
    logic       funds_ok;
    logic       need_more;
    logic       insert_now;

    vend_change_decode u_change (
        .nickel_ret_in (bus.nickel_ret_in),
        .dime_ret_in   (bus.dime_ret_in),
        .change_cents  (ret_cents),
        .illegal       (ret_illegal)
    );

    // Next-coin choice and the two conditions that lead into INSERT.
    always_comb begin
        next_coin  = pick_coin(n_left, d_left, q_left);
        funds_ok   = wallet_cents(n_left, d_left, q_left) >= PRICE_CENTS;
        need_more  = {1'b0, paid} < PRICE_CENTS;
        insert_now = (state == ST_CHECK && funds_ok) || (state == ST_GAP && need_more);
    end

    // Purchase FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            n_left           <= '0;
            d_left           <= '0;
            q_left           <= '0;
            paid             <= '0;
            wait_cnt         <= '0;
            bus.nickel_out   <= 1'b0;
            bus.dime_out     <= 1'b0;
            bus.quarter_out  <= 1'b0;
            bus.thanks_out   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.change_cents <= '0;
            bus.vend_ok      <= 1'b0;
            bus.err          <= ERR_NONE;
        end else begin
            // NOTE: non-blocking assignments here, so every branch sees the pre-edge state and later assignments win.
            bus.nickel_out  <= 1'b0;
            bus.dime_out    <= 1'b0;
            bus.quarter_out <= 1'b0;
            bus.thanks_out  <= 1'b0;
            bus.done        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_left           <= bus.nickel_cnt;
                        d_left           <= bus.dime_cnt;
                        q_left           <= bus.quarter_cnt;
                        paid             <= '0;
                        bus.change_cents <= '0;
                        bus.vend_ok      <= 1'b0;
                        bus.err          <= ERR_NONE;
                        bus.busy         <= 1'b1;
                        state            <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!funds_ok) begin
                        bus.err  <= ERR_FUNDS;
                        bus.done <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_INSERT: state <= ST_GAP;
                ST_GAP: begin
                    if (!need_more) begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT_VEND;
                    end
                end
                ST_WAIT_VEND: begin
                    if (bus.candy_in) begin
                        bus.change_cents <= ret_cents;
                        if (ret_illegal) bus.err <= ERR_CHANGE;
                        bus.thanks_out   <= 1'b1;
                        state            <= ST_THANK;
                    end else if (wait_cnt == LAST_WAIT) begin
                        bus.err  <= ERR_TIMEOUT;
                        bus.done <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_THANK: begin
                    bus.vend_ok <= (bus.err == ERR_NONE) &&
                                   (({1'b0, paid} - PRICE_CENTS) == {2'b00, bus.change_cents});
                    bus.done    <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Coin insertion is shared by CHECK and GAP; it overrides their state update.
            if (insert_now) begin
                state <= ST_INSERT;
                paid  <= paid + coin_cents(next_coin);
                case (next_coin)
                    COIN_QUARTER: begin
                        bus.quarter_out <= 1'b1;
                        q_left          <= q_left - 1'b1;
                    end
                    COIN_DIME: begin
                        bus.dime_out <= 1'b1;
                        d_left       <= d_left - 1'b1;
                    end
                    COIN_NICKEL: begin
                        bus.nickel_out <= 1'b1;
                        n_left         <= n_left - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vend_customer.sv
// Bench for vend_customer: directed purchases against a small machine model,
// with a scoreboard queue filled at start and drained by a done monitor.
module tb_vend_customer;
    import vend_pkg::*;

    localparam int PRICE = 25;
    localparam int TMO   = 8;

    typedef struct {
        int start_cyc;
        int lat;
        int change;
        int vok;
        int err;
        int nq;
        int nd;
        int nn;
        int nth;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   n_pushed = 0;
    exp_t sb[$];

    // Machine model configuration: candy delay into WAIT_VEND (-1 never,
    // -2 only during the gap cycle), and the change it reports.
    int m_cd = -1;
    int m_nret = 0;
    int m_dret = 0;

    vend_customer_if bus();

    vend_customer #(.PRICE(PRICE), .VEND_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_nickel"}, int'(bus.nickel_out), 0);
        check({tag, "_dime"}, int'(bus.dime_out), 0);
        check({tag, "_quarter"}, int'(bus.quarter_out), 0);
        check({tag, "_thanks"}, int'(bus.thanks_out), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_vend_ok"}, int'(bus.vend_ok), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_change"}, int'(bus.change_cents), 0);
    endtask

    // Monitor: counts pulses per purchase and scores each done against the queue.
    initial begin
        int cq = 0, cdm = 0, cn = 0, cth = 0;
        logic prev_coin = 1'b0;
        logic coin_now;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cq = 0; cdm = 0; cn = 0; cth = 0;
                prev_coin = 1'b0;
            end else begin
                coin_now = bus.nickel_out | bus.dime_out | bus.quarter_out;
                if (coin_now)
                    check("coin_spacing",
                          int'($onehot({bus.nickel_out, bus.dime_out, bus.quarter_out}) && !prev_coin), 1);
                cq  += int'(bus.quarter_out);
                cdm += int'(bus.dime_out);
                cn  += int'(bus.nickel_out);
                cth += int'(bus.thanks_out);
                if (bus.done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", cyc - e.start_cyc, e.lat);
                        check("change_cents", int'(bus.change_cents), e.change);
                        check("vend_ok", int'(bus.vend_ok), e.vok);
                        check("err", int'(bus.err), e.err);
                        check("quarters", cq, e.nq);
                        check("dimes", cdm, e.nd);
                        check("nickels", cn, e.nn);
                        check("thanks", cth, e.nth);
                        check("busy_at_done", int'(bus.busy), 1);
                    end
                    cq = 0; cdm = 0; cn = 0; cth = 0;
                end
                prev_coin = coin_now;
            end
        end
    end

    // Machine model: sums inserted coins and answers with candy once paid.
    initial begin
        int acc = 0;
        bus.candy_in      = 1'b0;
        bus.nickel_ret_in = 1'b0;
        bus.dime_ret_in   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = 0;
            end else begin
                acc += QUARTER_CENTS * int'(bus.quarter_out) + DIME_CENTS * int'(bus.dime_out)
                       + NICKEL_CENTS * int'(bus.nickel_out);
                if (acc >= PRICE) begin
                    acc = 0;
                    if (m_cd == -2) begin
                        @(negedge clk);
                    end else if (m_cd >= 0) begin
                        repeat (2 + m_cd) @(negedge clk);
                    end
                    if (m_cd != -1) begin
                        bus.candy_in      = 1'b1;
                        bus.nickel_ret_in = m_nret[0];
                        bus.dime_ret_in   = 2'(m_dret);
                        @(negedge clk);
                        bus.candy_in      = 1'b0;
                        bus.nickel_ret_in = 1'b0;
                        bus.dime_ret_in   = 2'b00;
                    end
                end
            end
        end
    end

    task automatic run_txn(input int n, input int d, input int q,
                           input int mcd, input int mnret, input int mdret, input int poke,
                           input int lat, input int chg, input int vok, input int err,
                           input int nq, input int nd, input int nn, input int nth);
        exp_t e;
        m_cd   = mcd;
        m_nret = mnret;
        m_dret = mdret;
        @(negedge clk);
        bus.nickel_cnt  = 3'(n);
        bus.dime_cnt    = 3'(d);
        bus.quarter_cnt = 2'(q);
        bus.start       = 1'b1;
        e.start_cyc = cyc;
        e.lat = lat; e.change = chg; e.vok = vok; e.err = err;
        e.nq = nq; e.nd = nd; e.nn = nn; e.nth = nth;
        sb.push_back(e);
        n_pushed++;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.nickel_cnt  = 3'd0;
        bus.dime_cnt    = 3'd0;
        bus.quarter_cnt = 2'd0;
        if (poke > 0) begin
            repeat (poke - 1) @(negedge clk);
            bus.nickel_cnt = 3'd7;
            bus.dime_cnt   = 3'd3;
            bus.start      = 1'b1;
            @(negedge clk);
            bus.start      = 1'b0;
            bus.nickel_cnt = 3'd0;
            bus.dime_cnt   = 3'd0;
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("txn_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Directed stimulus.
    initial begin
        bus.start       = 1'b0;
        bus.nickel_cnt  = 3'd0;
        bus.dime_cnt    = 3'd0;
        bus.quarter_cnt = 2'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        //      n  d  q   cd nr dr poke  lat chg vok err  q  d  n th
        run_txn(0, 0, 1,  0, 0, 0, 0,    6,  0, 1, 0,   1, 0, 0, 1);  // one quarter
        run_txn(0, 3, 0,  0, 1, 0, 0,   10,  5, 1, 0,   0, 3, 0, 1);  // three dimes, nickel back
        run_txn(2, 1, 0, -1, 0, 0, 0,    2,  0, 0, 1,   0, 0, 0, 0);  // 20c: insufficient
        run_txn(0, 0, 1, -1, 0, 0, 0,   12,  0, 0, 2,   1, 0, 0, 0);  // no candy: timeout
        run_txn(0, 0, 1,  0, 0, 2, 0,    6, 10, 0, 3,   1, 0, 0, 1);  // illegal dime code 10
        run_txn(2, 2, 0,  0, 0, 0, 0,   10,  0, 1, 0,   0, 2, 1, 1);  // dime, dime, nickel
        run_txn(0, 3, 0,  0, 0, 1, 0,   10, 10, 0, 0,   0, 3, 0, 1);  // wrong change returned
        run_txn(0, 0, 1,  7, 0, 0, 0,   13,  0, 1, 0,   1, 0, 0, 1);  // candy on last wait cycle
        run_txn(0, 0, 1, -2, 1, 0, 0,   12,  0, 0, 2,   1, 0, 0, 0);  // candy in GAP is ignored
        run_txn(4, 0, 0, -1, 0, 0, 0,    2,  0, 0, 1,   0, 0, 0, 0);  // 20c in nickels
        run_txn(5, 0, 0,  0, 0, 0, 0,   14,  0, 1, 0,   0, 0, 5, 1);  // exact 25c in nickels
        run_txn(7, 3, 1,  0, 0, 0, 0,    6,  0, 1, 0,   1, 0, 0, 1);  // quarter has priority
        run_txn(0, 0, 1,  0, 0, 3, 0,    6, 20, 0, 0,   1, 0, 0, 1);  // two dimes back, overpaid

        // Reset in the gap after the first dime abandons the purchase.
        m_cd = -1;
        @(negedge clk);
        bus.dime_cnt = 3'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dime_cnt = 3'd0;
        @(negedge clk);
        check("rst_first_dime", int'(bus.dime_out), 1);
        @(negedge clk);
        check("rst_busy_before", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1 check_idle("rst_mid");
        repeat (2) @(negedge clk);
        check_idle("rst_hold");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_restart_busy", int'(bus.busy), 0);
        check("rst_no_restart_dime", int'(bus.dime_out), 0);

        // A second start while busy must not disturb the purchase in flight.
        run_txn(0, 0, 1,  0, 0, 0, 2,    6,  0, 1, 0,   1, 0, 0, 1);

        repeat (20) @(negedge clk);
        check("done_count", n_done, n_pushed);
        check("final_busy", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the design wedges the bench.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

endmodule

// File: doc/vend_customer.md
VEND_CUSTOMER -- requirements
Module: vend_customer

Interface
REQ-001 Parameter PRICE, default 25: item price in cents; multiple of 5.
REQ-002 Parameter VEND_TIMEOUT, default 8: cycles to wait for candy after the last coin.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle purchase request; ignored while busy=1.
REQ-006 nickel_cnt  input  3  nickels in wallet, latched on accepted start.
REQ-007 dime_cnt  input  3  dimes in wallet, latched on accepted start.
REQ-008 quarter_cnt  input  2  quarters in wallet, latched on accepted start.
REQ-009 candy_in  input  1  vend strobe from the machine.
REQ-010 nickel_ret_in  input  1  nickel-change flag, valid with candy_in.
REQ-011 dime_ret_in  input  2  dime change, thermometer-coded: 00=0, 01=1, 11=2, 10 illegal; valid with candy_in.
REQ-012 nickel_out, dime_out, quarter_out  output  1 each  coin-insert pulses to the machine.
REQ-013 thanks_out  output  1  one-cycle acknowledge returning the machine to idle.
REQ-014 busy  output  1  high from the accepted start until done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 change_cents  output  6  returned change in cents, valid while done=1 and held until the next start.
REQ-017 vend_ok  output  1  returned change equals paid minus PRICE; valid with done.
REQ-018 err  output  2  00 none, 01 insufficient funds, 10 vend timeout, 11 illegal change code; valid with done.

Function
REQ-019 FSM states: IDLE, CHECK, INSERT, GAP, WAIT_VEND, THANK, DONE.
REQ-020 IDLE -> CHECK on start: latch the wallet counts; clear paid, change_cents, vend_ok and err.
REQ-021 CHECK: if 5*n + 10*d + 25*q < PRICE, go to DONE with err=01; no coin is inserted and thanks_out is not asserted.
REQ-022 INSERT: raise exactly one coin output for one cycle, by priority quarter > dime > nickel; decrement that coin's count; add its value to paid (7-bit).
REQ-023 GAP: one idle cycle after every coin; no two coin outputs are ever high in the same cycle or in consecutive cycles.
REQ-024 After GAP: go to INSERT if paid < PRICE, otherwise to WAIT_VEND; no further coins once paid >= PRICE.
REQ-025 WAIT_VEND: count cycles; candy_in=1 -> capture change = 5*nickel_ret_in + 10*popcount(dime_ret_in), then go to THANK.
REQ-026 In WAIT_VEND, dime_ret_in=10 together with candy_in sets err=11; the FSM still proceeds to THANK.
REQ-027 No candy_in within VEND_TIMEOUT cycles of entering WAIT_VEND: go to DONE with err=10 and no thanks_out.
REQ-028 THANK: thanks_out=1 for exactly one cycle, then DONE.
REQ-029 DONE: done=1 for one cycle; vend_ok = (err==00 and change == paid - PRICE); next state is IDLE.
REQ-030 Latency, PRICE=25 and one quarter: start at cycle 0; quarter_out at cycle 2; candy_in expected at cycle 4; thanks_out the cycle after candy_in is seen, done one cycle after that.
REQ-031 candy_in, nickel_ret_in and dime_ret_in are ignored outside WAIT_VEND.
REQ-032 A start pulse while busy=1 has no effect and is not queued.
REQ-033 All outputs are registered.

Reset
REQ-034 rst_n low forces IDLE: all coin outputs, thanks_out, done, busy, vend_ok = 0; err = 00; change_cents = 0; counters and paid = 0.
REQ-035 Reset mid-transaction abandons the purchase immediately; no coin or thanks pulse is emitted after reset asserts.

Structure
REQ-036 Shared package vend_pkg holds the coin values (5/10/25), the default PRICE, the err codes and the FSM state encoding, for use by both vend_customer and the machine.
REQ-037 Sub-module vend_change_decode is combinational: it takes nickel_ret_in and dime_ret_in and produces change cents and an illegal flag.

Verification
REQ-038 Wallet q=1, d=0, n=0, against the machine model -> one quarter_out pulse, candy, thanks_out, done; change_cents=0, vend_ok=1, err=00.
REQ-039 Wallet q=0, d=3, n=0 -> three dime pulses 2 cycles apart; paid=30; machine returns a nickel; change_cents=5, vend_ok=1.
REQ-040 Wallet q=0, d=1, n=2 -> no insert, done after CHECK with err=01; thanks_out never asserted.
REQ-041 Wallet q=1, candy_in tied low -> done 8 cycles after WAIT_VEND entry, err=10, no thanks_out.
REQ-042 Wallet q=1, candy_in with dime_ret_in=10 -> thanks_out asserted, err=11, vend_ok=0.
REQ-043 rst_n pulsed low during GAP after the first dime, then a start pulse while busy -> all outputs 0 immediately on reset; the start while busy has no effect on paid or state.
